// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: valid/ready word input, LSB-first serial output,
// configurable width and stop bits. Define UART_TX_PARITY_EN to add a parity bit.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_txd,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  baudEnd;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_SENSE = (PARITY_ODD != 0);
  logic parity_q, parity_d;
`else
  if (PARITY_ODD != 0) begin : gParityOddIgnored
  end
`endif

  assign baudEnd = (baud_q == BAUD_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // bit_q counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_d  = state_q;
    baud_d   = baudEnd ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (i_valid) begin
          state_d  = START;
          shift_d  = i_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_data;
`endif
        end
      end
      START: begin
        if (baudEnd) state_d = DATA;
      end
      DATA: begin
        if (baudEnd) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baudEnd) state_d = STOP;
      end
`endif
      STOP: begin
        if (baudEnd) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is computed from the next state so o_txd changes on the same edge as the state
  always_comb begin
    txd_d   = 1'b1;
    o_ready = (state_q == IDLE);
    o_busy  = (state_q != IDLE);
    o_done  = (state_q == STOP) && baudEnd && (bit_q == STOP_LAST);
    case (state_d)
      START:  txd_d = 1'b0;
      DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_d = parity_q ^ PARITY_SENSE;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  assign o_txd = txd_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame at CLKS_PER_BIT=4; honours UART_TX_PARITY_EN
// when the bench and design are compiled with it.
module tb_uart_tx_frame;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NA = (1 + 8 + P + 1) * CPB;
  localparam int NB = (1 + 8 + P + 2) * CPB;
  localparam int NC = (1 + 5 + P + 1) * CPB;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   passes = 0;

  logic       validA = 1'b0, txdA, readyA, busyA, doneA;
  logic [7:0] dataA = 8'h00;
  logic       validB = 1'b0, txdB, readyB, busyB, doneB;
  logic [7:0] dataB = 8'h00;
  logic       validC = 1'b0, txdC, readyC, busyC, doneC;
  logic [4:0] dataC = 5'h00;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dutA (
    .i_clk(clk), .i_reset(rstN), .i_valid(validA), .i_data(dataA),
    .o_ready(readyA), .o_txd(txdA), .o_busy(busyA), .o_done(doneA));

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dutB (
    .i_clk(clk), .i_reset(rstN), .i_valid(validB), .i_data(dataB),
    .o_ready(readyB), .o_txd(txdB), .o_busy(busyB), .o_done(doneB));

  uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dutC (
    .i_clk(clk), .i_reset(rstN), .i_valid(validC), .i_data(dataC),
    .o_ready(readyC), .o_txd(txdC), .o_busy(busyC), .o_done(doneC));

`ifdef UART_TX_PARITY_EN
  logic       validD = 1'b0, txdD, readyD, busyD, doneD;
  logic [7:0] dataD = 8'h00;
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dutD (
    .i_clk(clk), .i_reset(rstN), .i_valid(validD), .i_data(dataD),
    .o_ready(readyD), .o_txd(txdD), .o_busy(busyD), .o_done(doneD));
`endif

  // Expected line level for bit slot 'slot' of an even-parity frame carrying d
  function automatic logic expBit(input logic [8:0] d, input int nData, input int slot);
    logic [8:0] m;
    m = d;
    if (slot == 0) return 1'b0;
    if (slot <= nData) return m[slot-1];
    if (P == 1 && slot == nData + 1) return ^m;
    return 1'b1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({txdA, readyA, busyA, doneA} !== 4'b1100)
      $display("[TB] FAIL reset_A: got txd/ready/busy/done=%b required 1100", {txdA, readyA, busyA, doneA});
    else passes++;
    checks++; if ({txdB, readyB, busyB, doneB} !== 4'b1100)
      $display("[TB] FAIL reset_B: got txd/ready/busy/done=%b required 1100", {txdB, readyB, busyB, doneB});
    else passes++;
    checks++; if ({txdC, readyC, busyC, doneC} !== 4'b1100)
      $display("[TB] FAIL reset_C: got txd/ready/busy/done=%b required 1100", {txdC, readyC, busyC, doneC});
    else passes++;
    rstN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic e;
    validA = 1'b1; dataA = 8'hA5;
    @(negedge clk);
    validA = 1'b0; dataA = 8'h00;
    checks++; if ({readyA, busyA} !== 2'b01)
      $display("[TB] FAIL basic_handshake: got ready/busy=%b required 01", {readyA, busyA});
    else passes++;
    for (int i = 0; i < NA; i++) begin
      e = expBit({1'b0, 8'hA5}, 8, i / CPB);
      checks++; if (txdA !== e)
        $display("[TB] FAIL basic_txd cycle %0d: got %b required %b", i, txdA, e);
      else passes++;
      checks++; if (doneA !== (i == NA - 1))
        $display("[TB] FAIL basic_done cycle %0d: got %b required %b", i, doneA, (i == NA - 1));
      else passes++;
      @(negedge clk);
    end
    checks++; if ({txdA, readyA, busyA, doneA} !== 4'b1100)
      $display("[TB] FAIL basic_after: got txd/ready/busy/done=%b required 1100", {txdA, readyA, busyA, doneA});
    else passes++;
  endtask

  task automatic test_busy_ignored();
    logic e;
    logic sawStart;
    validA = 1'b1; dataA = 8'hA5;
    @(negedge clk);
    validA = 1'b0;
    for (int i = 0; i < NA; i++) begin
      if (i == 8) begin validA = 1'b1; dataA = 8'h3C; end
      if (i == 30) validA = 1'b0;
      e = expBit({1'b0, 8'hA5}, 8, i / CPB);
      checks++; if (txdA !== e)
        $display("[TB] FAIL busy_txd cycle %0d: got %b required %b", i, txdA, e);
      else passes++;
      checks++; if (readyA !== 1'b0)
        $display("[TB] FAIL busy_ready cycle %0d: got %b required 0", i, readyA);
      else passes++;
      @(negedge clk);
    end
    sawStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (txdA !== 1'b1 || busyA !== 1'b0) sawStart = 1'b1;
      @(negedge clk);
    end
    checks++; if (sawStart !== 1'b0)
      $display("[TB] FAIL busy_not_queued: got frame started=%b required 0", sawStart);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    logic e;
    logic doneSeen;
    validA = 1'b1; dataA = 8'hA5;
    @(negedge clk);
    validA = 1'b0;
    for (int i = 0; i < 17; i++) @(negedge clk);
    checks++; if (txdA !== 1'b0)
      $display("[TB] FAIL midreset_bit3: got %b required 0", txdA);
    else passes++;
    rstN = 1'b0;
    #1;
    checks++; if ({txdA, readyA, busyA, doneA} !== 4'b1100)
      $display("[TB] FAIL midreset_async: got txd/ready/busy/done=%b required 1100", {txdA, readyA, busyA, doneA});
    else passes++;
    doneSeen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (doneA !== 1'b0 || txdA !== 1'b1) doneSeen = 1'b1;
    end
    rstN = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (doneA !== 1'b0 || txdA !== 1'b1) doneSeen = 1'b1;
    end
    checks++; if (doneSeen !== 1'b0)
      $display("[TB] FAIL midreset_abandon: got activity=%b required 0", doneSeen);
    else passes++;
    validA = 1'b1; dataA = 8'h5A;
    @(negedge clk);
    validA = 1'b0;
    for (int i = 0; i < NA; i++) begin
      e = expBit({1'b0, 8'h5A}, 8, i / CPB);
      checks++; if (txdA !== e)
        $display("[TB] FAIL midreset_resend_txd cycle %0d: got %b required %b", i, txdA, e);
      else passes++;
      checks++; if (doneA !== (i == NA - 1))
        $display("[TB] FAIL midreset_resend_done cycle %0d: got %b required %b", i, doneA, (i == NA - 1));
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int   doneCount;
    logic extra;
    doneCount = 0;
    validB = 1'b1; dataB = 8'h00;
    @(negedge clk);
    dataB = 8'hFF;
    for (int i = 0; i <= 2 * NB; i++) begin
      if (i < NB) e = expBit(9'h000, 8, i / CPB);
      else if (i == NB) e = 1'b1;
      else e = expBit(9'h0FF, 8, (i - NB - 1) / CPB);
      checks++; if (txdB !== e)
        $display("[TB] FAIL b2b_txd cycle %0d: got %b required %b", i, txdB, e);
      else passes++;
      if (i == NB) begin
        checks++; if ({readyB, busyB} !== 2'b10)
          $display("[TB] FAIL b2b_idle_gap: got ready/busy=%b required 10", {readyB, busyB});
        else passes++;
      end
      checks++; if (doneB !== (i == NB - 1 || i == 2 * NB))
        $display("[TB] FAIL b2b_done cycle %0d: got %b required %b", i, doneB, (i == NB - 1 || i == 2 * NB));
      else passes++;
      if (doneB === 1'b1) doneCount++;
      if (i == NB + 1) validB = 1'b0;
      @(negedge clk);
    end
    checks++; if (doneCount != 2)
      $display("[TB] FAIL b2b_done_count: got %0d required 2", doneCount);
    else passes++;
    extra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (txdB !== 1'b1 || readyB !== 1'b1) extra = 1'b1;
      @(negedge clk);
    end
    checks++; if (extra !== 1'b0)
      $display("[TB] FAIL b2b_no_third: got activity=%b required 0", extra);
    else passes++;
  endtask

  task automatic test_data5();
    logic e;
    validC = 1'b1; dataC = 5'h15;
    @(negedge clk);
    validC = 1'b0;
    for (int i = 0; i < NC; i++) begin
      e = expBit({4'b0, 5'h15}, 5, i / CPB);
      checks++; if (txdC !== e)
        $display("[TB] FAIL data5_txd cycle %0d: got %b required %b", i, txdC, e);
      else passes++;
      checks++; if (doneC !== (i == NC - 1))
        $display("[TB] FAIL data5_done cycle %0d: got %b required %b", i, doneC, (i == NC - 1));
      else passes++;
      @(negedge clk);
    end
    checks++; if ({readyC, busyC} !== 2'b10)
      $display("[TB] FAIL data5_after: got ready/busy=%b required 10", {readyC, busyC});
    else passes++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    validA = 1'b1; dataA = 8'h07;
    validD = 1'b1; dataD = 8'h07;
    @(negedge clk);
    validA = 1'b0; validD = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i / CPB == 9) begin
        checks++; if (txdA !== 1'b1)
          $display("[TB] FAIL parity_even cycle %0d: got %b required 1", i, txdA);
        else passes++;
        checks++; if (txdD !== 1'b0)
          $display("[TB] FAIL parity_odd cycle %0d: got %b required 0", i, txdD);
        else passes++;
      end
      checks++; if ({doneA, doneD} !== {2{i == 43}})
        $display("[TB] FAIL parity_done cycle %0d: got %b required %b", i, {doneA, doneD}, {2{i == 43}});
      else passes++;
      @(negedge clk);
    end
    checks++; if ({readyD, busyD} !== 2'b10)
      $display("[TB] FAIL parity_after: got ready/busy=%b required 10", {readyD, busyD});
    else passes++;
  endtask
`endif

  initial begin
    $display("[TB] uart_tx_frame bench start, parity bits per frame = %0d", P);
    test_reset();
    test_basic_frame();
    test_busy_ignored();
    test_reset_midframe();
    test_back_to_back();
    test_data5();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
